// File: rtl/imm_decode_stage.sv
// Pipelined immediate decoder: valid/ready input, output register plus one skid entry.
// Optional macro IMM_TARGET_ADD_EN adds out_target = out_pc + out_imm carried with each entry.
`timescale 1ns/1ps
module imm_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr
`ifdef IMM_TARGET_ADD_EN
  ,
  output logic [PC_W-1:0] out_target
`endif
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high;
  // in_ready comes straight from the skid-valid flop, so it never looks at out_ready.

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
`ifdef IMM_TARGET_ADD_EN
    logic [PC_W-1:0] target;
`endif
  } entry_t;

  logic [6:0]         opc;
  logic [2:0]         funct3;
  logic               is_shift;
  logic signed [31:0] raw;
  logic [XLEN-1:0]    dec_imm;
  logic [2:0]         dec_fmt;
  entry_t             dec;
  entry_t             or_q;
  entry_t             sk_q;
  logic               or_valid;
  logic               sk_valid;
  logic               accept;
  logic               emit;

  assign opc      = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Every immediate fits a sign-extended 32-bit value; shamt/zimm are small positives,
  // so a single signed widening covers both sign- and zero-extension.
  always_comb begin
    raw     = '0;
    dec_fmt = FMT_ILL;
    case (opc)
      OPC_OP_IMM: begin
        dec_fmt = FMT_I;
        if (is_shift)
          raw = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
        else
          raw = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_LOAD, OPC_JALR: begin
        dec_fmt = FMT_I;
        raw     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          dec_fmt = FMT_I;
          if (is_shift) raw = {27'b0, in_instr[24:20]};
          else          raw = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        raw     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        raw     = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt = FMT_U;
        raw     = {in_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_fmt = FMT_J;
        raw     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
          dec_fmt = FMT_Z;
          raw     = {27'b0, in_instr[19:15]};
        end else begin
          dec_fmt = FMT_I;
          raw     = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OPC_OP: dec_fmt = FMT_R;
      OPC_OP32: dec_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
      default: dec_fmt = FMT_ILL;
    endcase
  end

  assign dec_imm = XLEN'(raw);

  always_comb begin
    dec         = '0;
    dec.imm     = dec_imm;
    dec.fmt     = dec_fmt;
    dec.illegal = (dec_fmt == FMT_ILL);
    dec.pc      = in_pc;
    dec.instr   = in_instr;
`ifdef IMM_TARGET_ADD_EN
    // JALR targets depend on rs1, so a PC-relative sum would be misleading there.
    if (dec_fmt == FMT_ILL || opc == OPC_JALR)
      dec.target = '0;
    else
      dec.target = in_pc + PC_W'($signed(dec_imm));
`endif
  end

  assign in_ready = !sk_valid;
  assign accept   = in_valid && in_ready;
  assign emit     = or_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
      or_q     <= '0;
      sk_q     <= '0;
    end else if (flush) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (sk_valid) begin
      // in_ready is low here, so only the skid-to-output move can happen.
      if (emit) begin
        or_q     <= sk_q;
        sk_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!or_valid || out_ready) begin
        or_q     <= dec;
        or_valid <= 1'b1;
      end else begin
        sk_q     <= dec;
        sk_valid <= 1'b1;
      end
    end else if (emit) begin
      or_valid <= 1'b0;
    end
  end

  assign out_valid   = or_valid;
  assign out_imm     = or_q.imm;
  assign out_fmt     = or_q.fmt;
  assign out_illegal = or_q.illegal;
  assign out_pc      = or_q.pc;
  assign out_instr   = or_q.instr;
`ifdef IMM_TARGET_ADD_EN
  assign out_target  = or_q.target;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share stimulus,
// each checked against its own expected queue filled from a reference decoder.
`timescale 1ns/1ps
module tb_imm_decode_stage;

  localparam int PC_W = 32;
  localparam int EW   = 164;  // {ill, fmt[2:0], imm[63:0], pc[31:0], instr[31:0], target[31:0]}

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            flush     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            out_ready = 1'b0;
  logic [31:0]     in_instr  = '0;
  logic [PC_W-1:0] in_pc     = '0;

  logic            in_ready32, out_valid32, out_illegal32;
  logic [31:0]     out_imm32, out_pc32, out_instr32, out_target32;
  logic [2:0]      out_fmt32;
  logic            in_ready64, out_valid64, out_illegal64;
  logic [63:0]     out_imm64;
  logic [31:0]     out_pc64, out_instr64, out_target64;
  logic [2:0]      out_fmt64;

  imm_decode_stage #(.XLEN(32), .PC_W(PC_W)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32),
    .out_pc(out_pc32), .out_instr(out_instr32)
`ifdef IMM_TARGET_ADD_EN
    , .out_target(out_target32)
`endif
  );

  imm_decode_stage #(.XLEN(64), .PC_W(PC_W)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64),
    .out_pc(out_pc64), .out_instr(out_instr64)
`ifdef IMM_TARGET_ADD_EN
    , .out_target(out_target64)
`endif
  );

`ifndef IMM_TARGET_ADD_EN
  assign out_target32 = '0;
  assign out_target64 = '0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit stop_rnd = 1'b0;
  logic [EW-1:0] exp32_q[$];
  logic [EW-1:0] exp64_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decoder written straight from the opcode table.
  function automatic logic [EW-1:0] model(input logic [31:0] ins, input logic [31:0] pc,
                                          input int xl);
    logic [63:0] imm, i_imm;
    logic [2:0]  fmt, f3;
    logic [6:0]  op;
    logic [31:0] tgt;
    op    = ins[6:0];
    f3    = ins[14:12];
    i_imm = {{52{ins[31]}}, ins[31:20]};
    imm   = '0;
    fmt   = 3'd7;
    case (op)
      7'h13: begin
        fmt = 3'd1;
        if (f3 == 3'd1 || f3 == 3'd5) imm = (xl == 64) ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
        else imm = i_imm;
      end
      7'h03, 7'h67: begin fmt = 3'd1; imm = i_imm; end
      7'h1B: if (xl == 64) begin
        fmt = 3'd1;
        imm = (f3 == 3'd1 || f3 == 3'd5) ? {59'd0, ins[24:20]} : i_imm;
      end
      7'h23: begin fmt = 3'd2; imm = {{52{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'h63: begin fmt = 3'd3; imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'h37, 7'h17: begin fmt = 3'd4; imm = {{32{ins[31]}}, ins[31:12], 12'd0}; end
      7'h6F: begin fmt = 3'd5; imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'h73: begin
        if (f3 >= 3'd5) begin fmt = 3'd6; imm = {59'd0, ins[19:15]}; end
        else begin fmt = 3'd1; imm = i_imm; end
      end
      7'h33: fmt = 3'd0;
      7'h3B: fmt = (xl == 64) ? 3'd0 : 3'd7;
      default: fmt = 3'd7;
    endcase
    if (xl == 32) imm[63:32] = '0;
    tgt = (fmt == 3'd7 || op == 7'h67) ? 32'd0 : pc + imm[31:0];
    return {fmt == 3'd7, fmt, imm, pc, ins, tgt};
  endfunction

  // scoreboard: pop on emit, push on accept, evaluated mid-cycle
  task automatic mon(input int xl, input logic rdy, input logic vld, input logic [63:0] imm,
                     input logic [2:0] fmt, input logic ill, input logic [31:0] pc,
                     input logic [31:0] ins, input logic [31:0] tgt);
    logic [EW-1:0] e;
    int n;
    n = (xl == 32) ? exp32_q.size() : exp64_q.size();
    check($sformatf("x%0d_out_valid", xl), {63'd0, vld}, {63'd0, n > 0});
    check($sformatf("x%0d_in_ready", xl), {63'd0, rdy}, {63'd0, n < 2});
    if (vld && out_ready && n > 0) begin
      e = (xl == 32) ? exp32_q.pop_front() : exp64_q.pop_front();
      check($sformatf("x%0d_instr", xl), {32'd0, ins}, {32'd0, e[63:32]});
      check($sformatf("x%0d_pc", xl), {32'd0, pc}, {32'd0, e[95:64]});
      check($sformatf("x%0d_imm", xl), imm, e[159:96]);
      check($sformatf("x%0d_fmt", xl), {61'd0, fmt}, {61'd0, e[162:160]});
      check($sformatf("x%0d_illegal", xl), {63'd0, ill}, {63'd0, e[163]});
`ifdef IMM_TARGET_ADD_EN
      check($sformatf("x%0d_target", xl), {32'd0, tgt}, {32'd0, e[31:0]});
`endif
    end
    if (flush) begin
      if (xl == 32) exp32_q.delete(); else exp64_q.delete();
    end else if (in_valid && rdy) begin
      if (xl == 32) exp32_q.push_back(model(in_instr, in_pc, 32));
      else          exp64_q.push_back(model(in_instr, in_pc, 64));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp32_q.delete();
      exp64_q.delete();
    end else begin
      mon(32, in_ready32, out_valid32, {32'd0, out_imm32}, out_fmt32, out_illegal32,
          out_pc32, out_instr32, out_target32);
      mon(64, in_ready64, out_valid64, out_imm64, out_fmt64, out_illegal64,
          out_pc64, out_instr64, out_target64);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = in_ready32;
      tick();
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done      = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      tick();
      done = (exp32_q.size() == 0) && (exp64_q.size() == 0);
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid32"}, {63'd0, out_valid32}, 64'd0);
    check({tag, "_valid64"}, {63'd0, out_valid64}, 64'd0);
    check({tag, "_imm32"}, {32'd0, out_imm32}, 64'd0);
    check({tag, "_fmt32"}, {61'd0, out_fmt32}, 64'd0);
    check({tag, "_ill32"}, {63'd0, out_illegal32}, 64'd0);
    check({tag, "_pc32"}, {32'd0, out_pc32}, 64'd0);
    check({tag, "_instr32"}, {32'd0, out_instr32}, 64'd0);
    check({tag, "_imm64"}, out_imm64, 64'd0);
  endtask

  logic [31:0] dir_instr[16] = '{
    32'hFFF00093, 32'hFE000EE3, 32'h03F09093, 32'h3002D073,
    32'h0000007F, 32'h00A00513, 32'h41F0D09B, 32'h0000003B,
    32'h00000033, 32'hFE112E23, 32'h80000017, 32'h00008067,
    32'h00000012, 32'hFFF00073, 32'h0000F073, 32'h43F0D093 };
  logic [31:0] dir_pc[16] = '{
    32'h0, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118,
    32'h11C, 32'h120, 32'h1000, 32'h124, 32'h128, 32'h12C, 32'h130, 32'h134 };
  logic [6:0] rnd_ops[15] = '{
    7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
    7'h6F, 7'h73, 7'h33, 7'h3B, 7'h7F, 7'h0F, 7'h12 };

  initial begin
    logic [31:0] r;
    int t0;
    #2;
    check_reset_outputs("rst_init");
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {63'd0, in_ready32}, 64'd1);
    tick();

    // directed decode patterns, flowing freely
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(dir_instr[i], dir_pc[i]);
    drain();

    // back-to-back throughput with downstream always ready
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(dir_instr[i], 32'h400 + 32'(i * 4));
    check("throughput_cycles", 64'(cyc - t0), 64'd8);
    drain();

    // backpressure: LUI held in output, JAL in skid
    out_ready = 1'b0;
    send(32'h12345037, 32'h200);
    send(32'h0000006F, 32'h204);
    @(negedge clk);
    check("bp_in_ready", {63'd0, in_ready32}, 64'd0);
    check("bp_or_imm", {32'd0, out_imm32}, 64'h12345000);
    check("bp_or_fmt", {61'd0, out_fmt32}, 64'd4);
    tick();
    tick();
    tick();
    drain();
    @(negedge clk);
    check("bp_ready_back", {63'd0, in_ready32}, 64'd1);
    tick();

    // flush with both entries full and a live input
    out_ready = 1'b0;
    send(32'h00100093, 32'h300);
    send(32'h00200113, 32'h304);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00300193;
    in_pc     = 32'h308;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_full_valid", {63'd0, out_valid32}, 64'd0);
    check("flush_full_ready", {63'd0, in_ready32}, 64'd1);
    tick();

    // flush overriding an accept that would otherwise be taken
    send(32'h00400213, 32'h30C);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00500293;
    in_pc    = 32'h310;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_drop_valid", {63'd0, out_valid32}, 64'd0);
    check("flush_drop_valid64", {63'd0, out_valid64}, 64'd0);
    tick();
    tick();

    // asynchronous reset in the middle of a cycle
    send(32'hFFF00093, 32'h500);
    send(32'hFE000EE3, 32'h504);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {63'd0, in_ready32}, 64'd1);
    tick();

    // random traffic with random downstream stalls
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) tick();
          r = $urandom();
          send({r[31:7], rnd_ops[$urandom_range(0, 14)]}, $urandom());
        end
        stop_rnd = 1'b1;
      end
      begin
        while (!stop_rnd) begin
          out_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
      end
    join
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Parametrised, pipelined successor to the combinational immediate generator.
- Sits between fetch and register-read in the pipelined core. Accepts instruction+PC over a valid/ready handshake and returns a registered XLEN-wide immediate, a format code and an illegal flag.
- Contains a 2-entry skid buffer so decode backpressure never drops an instruction.
- Supports RV32/RV64: I, S, B, U (LUI/AUIPC), J, shift-amount and CSR-zimm forms.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- PC_W, 32, PC width carried through.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (csr zimm), 7=illegal.
- out_illegal  out  1  unknown opcode.
- out_pc  out  PC_W  PC of the output entry.
- out_instr  out  32  instruction of the output entry.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0; skid entry invalid.
  - out_imm, out_fmt, out_illegal, out_pc and out_instr all 0.
  - in_ready=1 from the first cycle after rst deasserts.
- Transfers:
  - Accept when in_valid && in_ready.
  - Emit when out_valid && out_ready.
- Storage: output register (OR) plus skid register (SK).
- in_ready:
  - Registered; in_ready = !SK.valid.
  - Never depends combinationally on out_ready.
- Latency: accepted instruction appears on out_* the next cycle, if OR is empty or drains in that same cycle.
- Accept, with SK empty:
  - OR empty or draining → decoded result loads into OR.
  - Otherwise → result loads into SK and in_ready drops.
- Emit, with SK valid: SK moves to OR; SK clears; in_ready=1 next cycle.
- Ordering: strictly FIFO; no reordering; no duplication.
- Simultaneous accept and emit with OR full and SK empty: new entry goes to OR; throughput is 1/cycle.
- flush:
  - Clears OR and SK valid next cycle; payloads may keep stale values.
  - Overrides a same-cycle accept; the flushed-cycle input is dropped.
  - in_ready=1 next cycle.
- Decode is combinational on in_instr and registered on accept. Opcode map:
  - 0010011 (OP-IMM), 0000011 (LOAD), 1100111 (JALR): I-type, sign-extend [31:20], fmt 1.
  - OP-IMM shift exception, funct3 001/101: imm = zero-extended shamt.
    - XLEN=32: [24:20].
    - XLEN=64: [25:20].
  - 0011011 (OP-IMM-32): only legal when XLEN=64. I-type; shifts use [24:20]. With XLEN=32 → illegal.
  - 0100011: S-type {[31:25],[11:7]} sign-extended, fmt 2.
  - 1100011: B-type {[31],[7],[30:25],[11:8],0} sign-extended, fmt 3.
  - 0110111 (LUI), 0010111 (AUIPC): {[31:12],12'b0}, sign-extended to XLEN, fmt 4.
  - 1101111: J-type {[31],[19:12],[20],[30:21],0} sign-extended, fmt 5.
  - 1110011 (SYSTEM):
    - funct3 in {101,110,111}: zimm = [19:15] zero-extended, fmt 6.
    - Other funct3: I-type, fmt 1.
  - 0110011 (OP), 0111011 (OP-32, XLEN=64 only): imm 0, fmt 0.
  - Any other opcode, or bits[1:0]!=11: imm 0, fmt 7, out_illegal=1.
- out_illegal=1 only when fmt=7.

Optional Feature:
- Macro: IMM_TARGET_ADD_EN.
- When defined:
  - Adds output port out_target (PC_W): out_pc + out_imm truncated to PC_W, registered with the entry.
  - JALR target excluded: out_target=0 for opcode 1100111.
  - AUIPC, B and J entries carry PC+imm.
  - Illegal entries carry 0.
- When undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Basic I-type, XLEN=32: in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
- Branch: 0xFE000EE3 (beq x0,x0,-4) at in_pc=0x100 → out_imm=0xFFFFFFFC, fmt 3; with IMM_TARGET_ADD_EN, out_target=0xFC.
- Backpressure: out_ready=0; send 0x12345037 (LUI) then 0x0000006F (jal x0,0):
  - OR holds imm 0x12345000 (fmt 4); SK holds JAL; in_ready=0.
  - Raise out_ready → LUI emitted, then JAL (imm 0, fmt 5) in order; in_ready returns to 1.
- XLEN=64 shift/zimm:
  - 0x03F09093 (slli x1,x1,63) → out_imm=63, fmt 1.
  - 0x3002D073 (csrrwi x0,mstatus,5) → out_imm=5, fmt 6.
- Illegal: 0x0000007F → out_illegal=1, fmt 7, imm 0; next legal instruction decodes normally.
- Flush/reset mid-operation, with OR and SK both full:
  - flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, the input is not captured.
  - Repeat using rst asserted asynchronously mid-cycle → outputs 0 immediately.
